// File: rtl/relu_stream_scheduler_pkg.sv
// Shared types and sizing helpers for the streaming ReLU scheduler.
package relu_stream_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Number of LANES-wide RAM words covering the whole feature map.
  function automatic int unsigned beats_f(input int unsigned width,
                                          input int unsigned height,
                                          input int unsigned channels,
                                          input int unsigned lanes);
    return (width * height * channels) / lanes;
  endfunction

endpackage

// File: rtl/relu_stream_scheduler_lane.sv
// Single-element thresholded ReLU: pass x when it exceeds the signed threshold, else zero.
module relu_lane #(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic [BITWIDTH-1:0] x,
  input  logic [BITWIDTH-1:0] thr,
  output logic [BITWIDTH-1:0] y_c
);

  always_comb begin
    y_c = '0;
    if ($signed(x) > $signed(thr)) y_c = x;
  end

endmodule

// File: rtl/relu_stream_scheduler.sv
// Walks a feature map in RAM, LANES elements per beat, and streams thresholded
// ReLU results through a 2-entry output FIFO with valid/ready and last marker.
module relu_stream_scheduler
  import relu_stream_scheduler_pkg::*;
#(
  parameter int unsigned BITWIDTH    = 8,
  parameter int unsigned DATAWIDTH   = 28,
  parameter int unsigned DATAHEIGHT  = 28,
  parameter int unsigned DATACHANNEL = 3,
  parameter int unsigned LANES       = 4,
  parameter int unsigned ADDRWIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDRWIDTH-1:0]          cfg_base,
  input  logic [BITWIDTH-1:0]           cfg_threshold,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [ADDRWIDTH-1:0]          rd_addr,
  input  logic [LANES*BITWIDTH-1:0]     rd_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [LANES*BITWIDTH-1:0]     m_data,
  output logic                          m_last
);

  localparam int unsigned BEATS = beats_f(DATAWIDTH, DATAHEIGHT, DATACHANNEL, LANES);
  localparam int unsigned DW    = LANES * BITWIDTH;
  localparam logic [ADDRWIDTH-1:0] LAST_IDX = ADDRWIDTH'(BEATS - 1);

  state_e                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   base_q, base_d;
  logic [BITWIDTH-1:0]    thr_q, thr_d;
  logic [ADDRWIDTH-1:0]   beat_q, beat_d;
  logic [ADDRWIDTH-1:0]   out_cnt_q, out_cnt_d;
  logic [1:0]             occ_q, occ_d;
  logic                   inflight_q, inflight_d;
  logic [DW-1:0]          slot0_q, slot0_d;
  logic [DW-1:0]          slot1_q, slot1_d;

  logic [DW-1:0]          relu_c;
  logic                   pop_c;
  logic                   last_c;
  logic                   rd_en_c;
  logic                   done_c;
  logic [2:0]             level_c;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    relu_lane #(.BITWIDTH(BITWIDTH)) u_lane (
      .x   (rd_data[g*BITWIDTH +: BITWIDTH]),
      .thr (thr_q),
      .y_c (relu_c[g*BITWIDTH +: BITWIDTH])
    );
  end

  // Issue a read only if the FIFO can absorb it even when nothing drains.
  always_comb begin
    pop_c   = (occ_q != 2'd0) && m_ready;
    last_c  = (occ_q != 2'd0) && (out_cnt_q == LAST_IDX);
    level_c = 3'(occ_q) + 3'(inflight_q) - 3'(pop_c);
    rd_en_c = (state_q == ST_RUN) && (level_c < 3'd2);
    done_c  = (state_q == ST_DRAIN) && pop_c && last_c;
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_c;
  assign rd_en   = rd_en_c;
  assign rd_addr = base_q + beat_q;
  assign m_valid = (occ_q != 2'd0);
  assign m_data  = slot0_q;
  assign m_last  = last_c;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    thr_d      = thr_q;
    beat_d     = beat_q;
    out_cnt_d  = out_cnt_q;
    occ_d      = occ_q;
    inflight_d = rd_en_c;
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          base_d    = cfg_base;
          thr_d     = cfg_threshold;
          beat_d    = '0;
          out_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (rd_en_c && (beat_q == LAST_IDX)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (done_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rd_en_c) beat_d    = beat_q + ADDRWIDTH'(1);
    if (pop_c)   out_cnt_d = out_cnt_q + ADDRWIDTH'(1);

    // slot0 is always the head; returning read data lands behind whatever remains.
    case ({inflight_q, pop_c})
      2'b10: begin
        if (occ_q == 2'd0) slot0_d = relu_c;
        else               slot1_d = relu_c;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          slot0_d = relu_c;
        end else begin
          slot0_d = slot1_q;
          slot1_d = relu_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      thr_q      <= '0;
      beat_q     <= '0;
      out_cnt_q  <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      slot0_q    <= '0;
      slot1_q    <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      thr_q      <= thr_d;
      beat_q     <= beat_d;
      out_cnt_q  <= out_cnt_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
    end
  end

endmodule

// File: tb/tb_relu_stream_scheduler.sv
// Scoreboard bench for relu_stream_scheduler: RAM model, reference ReLU model, output monitor.
module tb_relu_stream_scheduler;

  localparam int BEATS = 588;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] cfg_base;
  logic [7:0]  cfg_threshold;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [31:0] rd_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  relu_stream_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_base      (cfg_base),
    .cfg_threshold (cfg_threshold),
    .busy          (busy),
    .done          (done),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] ram [0:65535];
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  logic [32:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int rd_cnt, pop_cnt, done_cnt, done_cyc, start_cyc;
  bit done_seen, zero_seen, ready_rand;
  bit prev_stall;
  logic [31:0] prev_data;
  logic prev_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: element k of word addr passes only when strictly greater than the threshold.
  function automatic logic [32:0] model(input logic [15:0] base, input int i, input logic [7:0] thr);
    logic [31:0] w;
    logic [31:0] o;
    int x;
    int t;
    w = ram[16'(int'(base) + i)];
    t = int'($signed(thr));
    o = '0;
    for (int l = 0; l < 4; l++) begin
      x = int'($signed(w[l*8 +: 8]));
      if (x > t) o[l*8 +: 8] = 8'(x);
    end
    return {(i == BEATS - 1), o};
  endfunction

  always @(posedge clk) begin
    #1;
    m_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on each handshake and polices stall stability.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (rd_en) rd_cnt++;
      if (rd_en && rd_addr == 16'h0000) zero_seen = 1'b1;
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_seen = 1'b1;
      end
      if (prev_stall) begin
        check("stall_valid", 64'(m_valid), 64'd1);
        check("stall_data", 64'(m_data), 64'(prev_data));
        check("stall_last", 64'(m_last), 64'(prev_last));
      end
      if (m_valid && m_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got %0h expected no beat (cycle %0d)", m_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 64'(m_data), 64'(e[31:0]));
          check("beat_last", 64'(m_last), 64'(e[32]));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},    64'(busy),    64'd0);
    check({tag, "_done"},    64'(done),    64'd0);
    check({tag, "_rd_en"},   64'(rd_en),   64'd0);
    check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_m_data"},  64'(m_data),  64'd0);
    check({tag, "_m_last"},  64'(m_last),  64'd0);
  endtask

  task automatic fill_pattern(input logic [15:0] base);
    for (int i = 0; i < BEATS; i++)
      ram[16'(int'(base) + i)] = {8'h80, 8'h7F, 8'(-i), 8'(i)};
  endtask

  // mode 1: extra starts at cycles 5 and 100; mode 2: extra start in the done cycle.
  task automatic do_run(input logic [15:0] base, input logic [7:0] thr, input bit rnd, input int mode);
    bit finished;
    int rel;
    for (int i = 0; i < BEATS; i++) exp_q.push_back(model(base, i, thr));
    ready_rand = rnd;
    rd_cnt = 0; done_cnt = 0; done_seen = 1'b0; pop_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; cfg_base = base; cfg_threshold = thr; start_cyc = cyc;
    finished = 1'b0;
    for (int k = 0; k < 8000 && !finished; k++) begin
      @(posedge clk); #1;
      rel = cyc - start_cyc;
      start = 1'b0; cfg_base = base; cfg_threshold = thr;
      if (mode == 1 && (rel == 5 || rel == 100)) begin
        start = 1'b1; cfg_base = base ^ 16'h5A5A; cfg_threshold = thr + 8'd5;
      end
      if (mode == 2 && rel == BEATS + 2) start = 1'b1;
      @(negedge clk);
      if (done_seen) finished = 1'b1;
    end
    if (!finished) begin
      checks++;
      failures++;
      $display("FAIL run_timeout: got no done expected done within 8000 cycles");
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("done_count", 64'(done_cnt), 64'd1);
    check("read_count", 64'(rd_cnt), 64'(BEATS));
    check("beats_outstanding", 64'(exp_q.size()), 64'd0);
    if (!rnd) check("done_cycle", 64'(done_cyc - start_cyc), 64'(BEATS + 2));
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_threshold = '0;
    ready_rand = 1'b0; m_ready = 1'b1; rd_cnt = 0; pop_cnt = 0; done_cnt = 0;
    done_seen = 1'b0; zero_seen = 1'b0; prev_stall = 1'b0;
    for (int a = 0; a < 65536; a++) ram[a] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Plain ReLU over the reference pattern, steady sink, plus a start in the done cycle.
    fill_pattern(16'h0000);
    do_run(16'h0000, 8'd0, 1'b0, 2);
    do_run(16'h0000, 8'd0, 1'b1, 0);

    // Threshold 10 on lanes {10, 11, -5, 100}.
    for (int i = 0; i < BEATS; i++) ram[16'h0100 + 16'(i)] = {8'd100, 8'hFB, 8'd11, 8'd10};
    do_run(16'h0100, 8'd10, 1'b1, 0);

    // Threshold -3 on lanes {-2, -3, rand, rand}.
    for (int i = 0; i < BEATS; i++)
      ram[16'h0400 + 16'(i)] = {8'($urandom), 8'($urandom), 8'hFD, 8'hFE};
    do_run(16'h0400, 8'hFD, 1'b0, 0);

    // Random data and threshold with restarts that must be ignored.
    do_run(16'h2000, 8'($urandom), 1'b1, 1);

    // Reset mid-run, then a fresh full run.
    for (int i = 0; i < BEATS; i++) exp_q.push_back(model(16'h3000, i, 8'd0));
    ready_rand = 1'b1; pop_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; cfg_base = 16'h3000; cfg_threshold = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4000 && pop_cnt < 200; k++) @(negedge clk);
    check("reached_beat_200", 64'(pop_cnt >= 200), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("midrun_reset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    do_run(16'h3000, 8'($urandom), 1'b1, 0);

    // Address wrap past 0xFFFF.
    fill_pattern(16'hFFF5);
    zero_seen = 1'b0;
    do_run(16'hFFF5, 8'd0, 1'b0, 0);
    check("addr_wrapped", 64'(zero_seen), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
